// File: rtl/hififo_pkg.sv
// Shared types for the HIFIFO traffic sequencer: data word and the run-state encoding.
package hififo_pkg;
  localparam int DATA_W = 64;

  typedef logic [DATA_W-1:0] hififo_word_t;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_RUN  = 1'b1
  } seq_state_e;
endpackage

// File: rtl/hififo_seq_checker.sv
// FPC-side checker: drains the FIFO every valid cycle and compares against an incrementing pattern.
module hififo_seq_checker import hififo_pkg::*; #(
  parameter hififo_word_t RX_START = 64'd0,
  parameter int           ERR_W    = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             fpc_valid,
  input  hififo_word_t     fpc_data,
  output logic             fpc_read,
  output logic [ERR_W-1:0] rx_count,
  output logic [ERR_W-1:0] err_count,
  output hififo_word_t     first_err
);

  logic [ERR_W-1:0] rx_q, rx_d;
  logic [ERR_W-1:0] err_q, err_d;
  hififo_word_t     exp_q, exp_d;
  hififo_word_t     first_q, first_d;

  assign fpc_read = run & fpc_valid;

  always_comb begin
    rx_d    = rx_q;
    err_d   = err_q;
    exp_d   = exp_q;
    first_d = first_q;
    if (fpc_read) begin
      rx_d = rx_q + ERR_W'(1);
      if (fpc_data == exp_q) begin
        exp_d = exp_q + 64'd1;
      end else begin
        // Resync on the received word so one dropped/extra word costs a single error.
        exp_d = fpc_data + 64'd1;
        if (err_q != '1) err_d = err_q + ERR_W'(1);
        if (err_q == '0) first_d = fpc_data;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_q    <= '0;
      err_q   <= '0;
      exp_q   <= RX_START;
      first_q <= '0;
    end else begin
      rx_q    <= rx_d;
      err_q   <= err_d;
      exp_q   <= exp_d;
      first_q <= first_d;
    end
  end

  assign rx_count  = rx_q;
  assign err_count = err_q;
  assign first_err = first_q;

endmodule

// File: rtl/hififo_sequencer.sv
// HIFIFO loopback traffic endpoint: checks the FPC stream and generates the TPC stream.
module hififo_sequencer import hififo_pkg::*; #(
  parameter hififo_word_t TX_START = 64'd0,
  parameter hififo_word_t RX_START = 64'd0,
  parameter int           ERR_W    = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             fpc_valid,
  input  hififo_word_t     fpc_data,
  output logic             fpc_read,
  input  logic             tpc_ready,
  output logic             tpc_write,
  output hififo_word_t     tpc_data,
  output logic [ERR_W-1:0] rx_count,
  output logic [ERR_W-1:0] err_count,
  output hififo_word_t     first_err
);

  // Handshakes: FPC word transfers on any edge with fpc_valid & fpc_read (FWFT head);
  // TPC word transfers on any edge with tpc_write, tpc_ready having promised 2 words of slack.
  seq_state_e   state_q, state_d;
  logic         run;
  logic         write_q, write_d;
  hififo_word_t data_q, data_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      SEQ_IDLE: state_d = SEQ_RUN;
      SEQ_RUN:  state_d = SEQ_RUN;
      default:  state_d = SEQ_IDLE;
    endcase
  end

  assign run = (state_q == SEQ_RUN);

  always_comb begin
    write_d = run & tpc_ready;
    data_d  = data_q;
    if (write_q) data_d = data_q + 64'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= SEQ_IDLE;
      write_q <= 1'b0;
      data_q  <= TX_START;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      data_q  <= data_d;
    end
  end

  assign tpc_write = write_q;
  assign tpc_data  = data_q;

  hififo_seq_checker #(
    .RX_START (RX_START),
    .ERR_W    (ERR_W)
  ) u_checker (
    .clock     (clock),
    .reset     (reset),
    .run       (run),
    .fpc_valid (fpc_valid),
    .fpc_data  (fpc_data),
    .fpc_read  (fpc_read),
    .rx_count  (rx_count),
    .err_count (err_count),
    .first_err (first_err)
  );

endmodule

// File: tb/tb_hififo_sequencer.sv
// Bench for hififo_sequencer: default instance plus a wrap/saturation instance (narrow counters).
module tb_hififo_sequencer;
  import hififo_pkg::*;

  localparam hififo_word_t B_START = 64'hFFFF_FFFF_FFFF_FFFE;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic         fpc_valid, fpc_read, tpc_ready, tpc_write;
  hififo_word_t fpc_data, tpc_data, first_err;
  logic [31:0]  rx_count, err_count;

  logic         b_fpc_valid, b_fpc_read, b_tpc_ready, b_tpc_write;
  hififo_word_t b_fpc_data, b_tpc_data, b_first_err;
  logic [1:0]   b_rx_count, b_err_count;

  hififo_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .fpc_valid (fpc_valid),
    .fpc_data  (fpc_data),
    .fpc_read  (fpc_read),
    .tpc_ready (tpc_ready),
    .tpc_write (tpc_write),
    .tpc_data  (tpc_data),
    .rx_count  (rx_count),
    .err_count (err_count),
    .first_err (first_err)
  );

  hififo_sequencer #(
    .TX_START (B_START),
    .RX_START (B_START),
    .ERR_W    (2)
  ) dut_b (
    .clock     (clock),
    .reset     (reset),
    .fpc_valid (b_fpc_valid),
    .fpc_data  (b_fpc_data),
    .fpc_read  (b_fpc_read),
    .tpc_ready (b_tpc_ready),
    .tpc_write (b_tpc_write),
    .tpc_data  (b_tpc_data),
    .rx_count  (b_rx_count),
    .err_count (b_err_count),
    .first_err (b_first_err)
  );

  // scoreboard
  int          n_tests = 0;
  int          n_fail  = 0;
  int          a_writes = 0;
  int          b_writes = 0;
  logic        run_m = 1'b0;
  logic [63:0] exp_q[$];
  logic [63:0] b_exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    check("fpc_read", 64'(fpc_read), 64'(run_m & fpc_valid));
    check("b_fpc_read", 64'(b_fpc_read), 64'(run_m & b_fpc_valid));
    if (tpc_write === 1'b1) begin
      a_writes++;
      if (exp_q.size() == 0) check("tpc_extra", 64'd1, 64'd0);
      else check("tpc_data", tpc_data, exp_q.pop_front());
    end
    if (b_tpc_write === 1'b1) begin
      b_writes++;
      if (b_exp_q.size() == 0) check("b_tpc_extra", 64'd1, 64'd0);
      else check("b_tpc_data", b_tpc_data, b_exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    run_m = 1'b0;
    fpc_valid = 1'b0;
    tpc_ready = 1'b0;
    b_fpc_valid = 1'b0;
    b_tpc_ready = 1'b0;
    exp_q.delete();
    b_exp_q.delete();
    repeat (2) tick();
    reset = 1'b1;
    tick();
    run_m = 1'b1;
  endtask

  task automatic feed(input logic [63:0] w);
    fpc_valid = 1'b1;
    fpc_data  = w;
    tick();
    fpc_valid = 1'b0;
  endtask

  task automatic b_feed(input logic [63:0] w);
    b_fpc_valid = 1'b1;
    b_fpc_data  = w;
    tick();
    b_fpc_valid = 1'b0;
  endtask

  logic [63:0] seq4[5] = '{64'd0, 64'd1, 64'd2, 64'd7, 64'd8};
  logic [63:0] seq6[4] = '{64'd0, 64'd1, 64'd5, 64'd6};

  initial begin
    fpc_valid = 1'b1;
    fpc_data  = '0;
    tpc_ready = 1'b1;
    b_fpc_valid = 1'b0;
    b_fpc_data  = '0;
    b_tpc_ready = 1'b0;
    reset = 1'b0;

    // reset held 5 cycles with traffic offered
    repeat (5) tick();
    check("rst_fpc_read", 64'(fpc_read), 64'd0);
    check("rst_tpc_write", 64'(tpc_write), 64'd0);
    check("rst_tpc_data", tpc_data, 64'd0);
    check("rst_rx", 64'(rx_count), 64'd0);
    check("rst_err", 64'(err_count), 64'd0);
    check("rst_first", first_err, 64'd0);
    check("rst_b_tpc_data", b_tpc_data, B_START);
    reset = 1'b1;
    #1;
    check("rel_fpc_read", 64'(fpc_read), 64'd0);
    check("rel_tpc_write", 64'(tpc_write), 64'd0);
    fpc_valid = 1'b0;
    tpc_ready = 1'b0;
    tick();
    run_m = 1'b1;
    check("edge1_tpc_write", 64'(tpc_write), 64'd0);
    check("edge1_tpc_data", tpc_data, 64'd0);

    // TPC burst of 10 then stop
    for (int i = 0; i < 10; i++) exp_q.push_back(64'(i));
    a_writes = 0;
    tpc_ready = 1'b1;
    repeat (10) tick();
    tpc_ready = 1'b0;
    check("late_write", 64'(tpc_write), 64'd1);
    tick();
    check("write_stop", 64'(tpc_write), 64'd0);
    check("tpc_next", tpc_data, 64'd10);
    check("tpc_count", 64'(a_writes), 64'd10);
    check("tpc_q_empty", 64'(exp_q.size()), 64'd0);

    // clean FPC stream 0..99
    for (int i = 0; i < 100; i++) feed(64'(i));
    check("clean_rx", 64'(rx_count), 64'd100);
    check("clean_err", 64'(err_count), 64'd0);
    check("clean_first", first_err, 64'd0);

    // gap in the stream, resync, first_err sticks
    do_reset();
    for (int i = 0; i < 5; i++) feed(seq4[i]);
    check("gap_err", 64'(err_count), 64'd1);
    check("gap_first", first_err, 64'd7);
    check("gap_rx", 64'(rx_count), 64'd5);
    feed(64'd9);
    check("resync_err", 64'(err_count), 64'd1);
    feed(64'd20);
    check("second_err", 64'(err_count), 64'd2);
    check("first_sticks", first_err, 64'd7);

    // FPC valid toggling
    do_reset();
    for (int i = 0; i < 16; i++) begin
      feed(64'(i));
      fpc_data = {$urandom, $urandom};
      tick();
    end
    check("toggle_rx", 64'(rx_count), 64'd16);
    check("toggle_err", 64'(err_count), 64'd0);

    // wrap instance: TPC wraps, RX expected wraps, counters wrap/saturate
    b_exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFE);
    b_exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    b_exp_q.push_back(64'd0);
    b_writes = 0;
    b_tpc_ready = 1'b1;
    repeat (3) tick();
    b_tpc_ready = 1'b0;
    tick();
    check("b_tpc_count", 64'(b_writes), 64'd3);
    check("b_tpc_next", b_tpc_data, 64'd1);
    check("b_q_empty", 64'(b_exp_q.size()), 64'd0);
    b_feed(64'hFFFF_FFFF_FFFF_FFFE);
    b_feed(64'hFFFF_FFFF_FFFF_FFFF);
    b_feed(64'd0);
    check("b_rx3", 64'(b_rx_count), 64'd3);
    check("b_wrap_err", 64'(b_err_count), 64'd0);
    b_feed(64'd1);
    check("b_rx_wrap", 64'(b_rx_count), 64'd0);
    b_feed(64'd5);
    b_feed(64'd9);
    b_feed(64'd13);
    check("b_err3", 64'(b_err_count), 64'd3);
    b_feed(64'd17);
    check("b_err_sat", 64'(b_err_count), 64'd3);
    check("b_first", b_first_err, 64'd5);

    // reset mid-stream
    do_reset();
    for (int i = 0; i < 20; i++) exp_q.push_back(64'(i));
    tpc_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fpc_valid = 1'b1;
      fpc_data  = seq6[i];
      tick();
    end
    check("mid_first_pre", first_err, 64'd5);
    reset = 1'b0;
    run_m = 1'b0;
    #1;
    check("mid_tpc_write", 64'(tpc_write), 64'd0);
    check("mid_tpc_data", tpc_data, 64'd0);
    check("mid_rx", 64'(rx_count), 64'd0);
    check("mid_err", 64'(err_count), 64'd0);
    check("mid_first", first_err, 64'd0);
    check("mid_fpc_read", 64'(fpc_read), 64'd0);
    exp_q.delete();
    fpc_valid = 1'b0;
    tpc_ready = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    run_m = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(64'(i));
    a_writes = 0;
    tpc_ready = 1'b1;
    repeat (3) tick();
    tpc_ready = 1'b0;
    tick();
    check("restart_count", 64'(a_writes), 64'd3);
    check("restart_next", tpc_data, 64'd3);
    feed(64'd0);
    feed(64'd1);
    check("restart_rx", 64'(rx_count), 64'd2);
    check("restart_err", 64'(err_count), 64'd0);

    check("final_q_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
